mmio_bus_bridge: RTL and testbench
==================================

Name: mmio_bus_bridge

Overview:
- Parametrised memory-mapped IO bridge between the CPU data port and NUM_CH peripheral channels (LED, switch, tube, UART, audio, ...).
- Decodes an aligned IO window into equal per-channel regions.
- Runs a request/ack handshake with each peripheral, which may insert wait states.
- Times out on dead channels and returns error responses, adding what fixed-decode IO glue lacks.

Parameters:
NUM_CH, 4, number of peripheral channels; power of 2, 2..16
ADDR_W, 32, CPU address width
DATA_W, 32, data width
IO_BASE, 32'hFFFFFC00, window base; aligned to NUM_CH<<CH_SPAN_LOG2
CH_SPAN_LOG2, 4, log2 bytes per channel region
TIMEOUT, 15, max wait cycles before error; 1..255
ERR_DATA, 32'hDEADBEEF, read data returned on error

Ports:
iCpuClock  in  1  clock
iCpuReset  in  1  asynchronous, active-high reset
iReqValid  in  1  CPU request valid
iReqWrite  in  1  1=write, 0=read
iReqAddr  in  ADDR_W  byte address
iReqWData  in  DATA_W  write data
oReqReady  out  1  bridge can accept a request
oRspValid  out  1  one-cycle response strobe
oRspRData  out  DATA_W  read data (registered)
oRspError  out  1  error flag, qualified by oRspValid
oChSel  out  NUM_CH  one-hot channel select
oChWrite  out  1  write strobe to selected channel
oChAddr  out  CH_SPAN_LOG2  offset within channel region
oChWData  out  DATA_W  write data to channel
iChAck  in  NUM_CH  per-channel ack
iChRData  in  NUM_CH*DATA_W  flattened read data; channel k at [k*DATA_W +: DATA_W]
oTimeoutCount  out  8  saturating count of timeouts
oLastErrAddr  out  ADDR_W  address of the most recent error

Behaviour:
- Reset (async, immediate): state=IDLE; every output 0 except oReqReady=1. Counters and latches cleared. A transaction in flight is abandoned, with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - oReqReady=1.
  - On iReqValid at a clock edge, latch write, address and data.
  - offset = addr - IO_BASE. Hit when addr >= IO_BASE and offset < (NUM_CH<<CH_SPAN_LOG2).
  - ch = offset>>CH_SPAN_LOG2; oChAddr = offset[CH_SPAN_LOG2-1:0].
  - Hit -> WAIT, wait counter=0. Miss -> RESP with error.
- WAIT:
  - oReqReady=0; oChSel=1<<ch.
  - oChWrite, oChAddr and oChWData are stable for the whole state.
  - iChAck[ch] high at an edge: capture iChRData slice ch (reads) or 0 (writes) into oRspRData, error=0, -> RESP.
  - No ack: counter++. When counter reaches TIMEOUT with no ack -> RESP with error.
  - Ack and timeout in the same cycle: ack wins.
  - Acks on non-selected channels are ignored.
- RESP:
  - oRspValid=1 for exactly one cycle; oChSel=0; -> IDLE.
  - Error case: oRspRData=ERR_DATA for reads and 0 for writes; oRspError=1; oLastErrAddr=latched addr.
  - Timeout errors also increment oTimeoutCount, saturating at 255. Decode misses do not increment it.
- oRspRData and oRspError hold their values until the next response.
- Latency: accept at edge N; WAIT during cycle N+1.
  - Ack in the first WAIT cycle: oRspValid in cycle N+2; oReqReady high again in cycle N+3.
  - Each wait state adds 1 cycle.
  - Timeout: oRspValid TIMEOUT+1 cycles after WAIT entry.
- Decode miss: oRspValid in cycle N+1; no channel is ever selected.
- One outstanding transaction at a time. iReqValid is ignored outside IDLE, and the CPU must hold it until accepted.
- Wait counter width is $clog2(TIMEOUT+1).

Test Plan:
- Read 0xFFFFFC24 (ch2, offset 4); ch2 acks after 2 wait cycles with 0x0000A5A5 -> oChSel=4'b0100, oChAddr=4; oRspValid 4 cycles after accept, rdata=0x0000A5A5, error=0.
- Write 0x12345678 to 0xFFFFFC00 (ch0); ack in first WAIT cycle -> oChWrite=1, oChWData=0x12345678; oRspValid at N+2, error=0, rdata=0.
- Read 0x00001000 (decode miss) -> oChSel stays 0; oRspValid at N+1; rdata=0xDEADBEEF, error=1; oLastErrAddr=0x00001000; oTimeoutCount unchanged.
- Read ch3 with no ack, TIMEOUT=15 -> error response 16 cycles after WAIT entry; rdata=0xDEADBEEF; oTimeoutCount=1. Repeat 256 times -> count saturates at 255.
- Read ch1 while ch0 and ch2 pulse ack -> stays in WAIT. ch1 ack on the same cycle the counter hits TIMEOUT -> error=0, ch1 data returned.
- Assert iCpuReset mid-WAIT -> oChSel=0 and oReqReady=1 immediately, no oRspValid. A following read to ch2 completes normally.

Source files
------------

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: decodes an aligned IO window into NUM_CH equal channel
// regions, runs a request/ack handshake with the selected peripheral, and
// turns decode misses and dead channels into error responses.
module mmio_bus_bridge #(
  parameter int                NUM_CH       = 4,
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] IO_BASE      = 32'hFFFFFC00,
  parameter int                CH_SPAN_LOG2 = 4,
  parameter int                TIMEOUT      = 15,
  parameter logic [DATA_W-1:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic                     iCpuClock,
  input  logic                     iCpuReset,
  input  logic                     iReqValid,
  input  logic                     iReqWrite,
  input  logic [ADDR_W-1:0]        iReqAddr,
  input  logic [DATA_W-1:0]        iReqWData,
  output logic                     oReqReady,
  output logic                     oRspValid,
  output logic [DATA_W-1:0]        oRspRData,
  output logic                     oRspError,
  output logic [NUM_CH-1:0]        oChSel,
  output logic                     oChWrite,
  output logic [CH_SPAN_LOG2-1:0]  oChAddr,
  output logic [DATA_W-1:0]        oChWData,
  input  logic [NUM_CH-1:0]        iChAck,
  input  logic [NUM_CH*DATA_W-1:0] iChRData,
  output logic [7:0]               oTimeoutCount,
  output logic [ADDR_W-1:0]        oLastErrAddr
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(NUM_CH) << CH_SPAN_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic [NUM_CH-1:0]       ch_sel_q, ch_sel_d;
  logic                    ch_write_q, ch_write_d;
  logic [CH_SPAN_LOG2-1:0] ch_addr_q, ch_addr_d;
  logic [DATA_W-1:0]       ch_wdata_q, ch_wdata_d;
  logic [7:0]              tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_W-1:0]       last_err_q, last_err_d;

  logic [ADDR_W-1:0]       req_offset;
  logic                    req_hit;
  logic [CH_W-1:0]         req_ch;
  logic [DATA_W-1:0]       ch_rdata [NUM_CH];

  // Unflatten the per-channel read data bus
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rdata
    assign ch_rdata[gi] = iChRData[gi*DATA_W +: DATA_W];
  end

  // Window decode of the incoming CPU address
  always_comb begin
    req_offset = iReqAddr - IO_BASE;
    req_hit    = (iReqAddr >= IO_BASE) && (req_offset < WIN_BYTES);
    req_ch     = req_offset[CH_SPAN_LOG2 +: CH_W];
  end

  // Next-state and next-output logic for the IDLE/WAIT/RESP handshake
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    ch_sel_d    = ch_sel_q;
    ch_write_d  = ch_write_q;
    ch_addr_d   = ch_addr_q;
    ch_wdata_d  = ch_wdata_q;
    tmo_cnt_d   = tmo_cnt_q;
    last_err_d  = last_err_q;
    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          write_d     = iReqWrite;
          addr_d      = iReqAddr;
          ch_d        = req_ch;
          ch_addr_d   = req_offset[CH_SPAN_LOG2-1:0];
          ch_wdata_d  = iReqWData;
          req_ready_d = 1'b0;
          if (req_hit) begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            ch_sel_d   = NUM_CH'(1) << req_ch;
            ch_write_d = iReqWrite;
          end else begin
            // Decode miss: answer straight away, never touch a channel
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = iReqWrite ? '0 : ERR_DATA;
            last_err_d  = iReqAddr;
          end
        end
      end
      S_WAIT: begin
        if (iChAck[ch_q]) begin
          // A real ack beats a timeout landing on the same edge
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = write_q ? '0 : ch_rdata[ch_q];
          ch_sel_d    = '0;
          ch_write_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : ERR_DATA;
          last_err_d  = addr_q;
          ch_sel_d    = '0;
          ch_write_d  = 1'b0;
          if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      ch_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      ch_sel_q    <= '0;
      ch_write_q  <= 1'b0;
      ch_addr_q   <= '0;
      ch_wdata_q  <= '0;
      tmo_cnt_q   <= '0;
      last_err_q  <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      ch_sel_q    <= ch_sel_d;
      ch_write_q  <= ch_write_d;
      ch_addr_q   <= ch_addr_d;
      ch_wdata_q  <= ch_wdata_d;
      tmo_cnt_q   <= tmo_cnt_d;
      last_err_q  <= last_err_d;
    end
  end

  assign oReqReady     = req_ready_q;
  assign oRspValid     = rsp_valid_q;
  assign oRspRData     = rsp_rdata_q;
  assign oRspError     = rsp_error_q;
  assign oChSel        = ch_sel_q;
  assign oChWrite      = ch_write_q;
  assign oChAddr       = ch_addr_q;
  assign oChWData      = ch_wdata_q;
  assign oTimeoutCount = tmo_cnt_q;
  assign oLastErrAddr  = last_err_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb_mmio_bus_bridge: randomized and directed transactions against a
// transaction-level reference model of the bridge.
module tb_mmio_bus_bridge;
  localparam int          NUM_CH  = 4;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 15;
  localparam logic [31:0] BASE    = 32'hFFFFFC00;
  localparam logic [31:0] ERR     = 32'hDEADBEEF;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     iReqValid = 1'b0, iReqWrite = 1'b0;
  logic [31:0]              iReqAddr = '0, iReqWData = '0;
  logic                     oReqReady, oRspValid, oRspError, oChWrite;
  logic [31:0]              oRspRData, oChWData, oLastErrAddr;
  logic [NUM_CH-1:0]        oChSel;
  logic [3:0]               oChAddr;
  logic [NUM_CH-1:0]        iChAck = '0;
  logic [NUM_CH*DATA_W-1:0] iChRData;
  logic [7:0]               oTimeoutCount;

  logic [31:0] chdata [NUM_CH];
  int checks = 0, errors = 0;

  // reference model state
  int          m_tmo = 0;
  logic [31:0] m_last_err = '0;
  bit          e_hit;
  int          e_ch, e_off, e_lat;
  logic [31:0] e_rdata;
  logic        e_err;

  // observations of the last transaction
  int          r_lat;
  logic [31:0] r_rdata, r_wd1, r_rdata_after;
  logic        r_err, r_wr1, r_ready_after, r_valid_after;
  logic [3:0]  r_sel1, r_addr1, r_sel_any;
  bit          r_unstable;

  always #5 clk = ~clk;

  always_comb begin
    iChRData = '0;
    for (int k = 0; k < NUM_CH; k++) iChRData[k*DATA_W +: DATA_W] = chdata[k];
  end

  mmio_bus_bridge dut (
    .iCpuClock(clk), .iCpuReset(rst),
    .iReqValid(iReqValid), .iReqWrite(iReqWrite), .iReqAddr(iReqAddr), .iReqWData(iReqWData),
    .oReqReady(oReqReady), .oRspValid(oRspValid), .oRspRData(oRspRData), .oRspError(oRspError),
    .oChSel(oChSel), .oChWrite(oChWrite), .oChAddr(oChAddr), .oChWData(oChWData),
    .iChAck(iChAck), .iChRData(iChRData),
    .oTimeoutCount(oTimeoutCount), .oLastErrAddr(oLastErrAddr)
  );

  // Transaction-level model: latency, data, error and counters from the rules
  task automatic model_txn(input logic wr, input logic [31:0] addr, input int delay);
    longint unsigned a, b, span;
    a = addr; b = BASE; span = NUM_CH * 16;
    e_hit = (a >= b) && ((a - b) < span);
    e_ch  = e_hit ? int'((a - b) / 16) : 0;
    e_off = e_hit ? int'((a - b) % 16) : 0;
    if (!e_hit) begin
      e_lat = 1; e_err = 1'b1; e_rdata = wr ? 32'h0 : ERR; m_last_err = addr;
    end else if (delay >= 0 && delay <= TIMEOUT) begin
      e_lat = delay + 2; e_err = 1'b0; e_rdata = wr ? 32'h0 : chdata[e_ch];
    end else begin
      e_lat = TIMEOUT + 2; e_err = 1'b1; e_rdata = wr ? 32'h0 : ERR; m_last_err = addr;
      if (m_tmo < 255) m_tmo++;
    end
  endtask

  // Drive one request and act as the peripheral; ack comes after `delay` wait cycles
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_ch, input int delay, input bit noise, input bit hold);
    logic [NUM_CH-1:0] ack;
    iReqValid = 1'b1; iReqWrite = wr; iReqAddr = addr; iReqWData = wdata; iChAck = '0;
    @(posedge clk); #1;
    r_lat = 0; r_rdata = '0; r_err = 1'b0; r_unstable = 0; r_sel_any = '0;
    r_sel1 = '0; r_wr1 = 1'b0; r_addr1 = '0; r_wd1 = '0;
    if (hold) begin
      iReqWrite = ~wr; iReqAddr = $urandom; iReqWData = $urandom;
    end else iReqValid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (oRspValid === 1'b1) begin
        r_lat = cyc; r_rdata = oRspRData; r_err = oRspError;
        break;
      end
      r_sel_any |= oChSel;
      if (cyc == 1) begin
        r_sel1 = oChSel; r_wr1 = oChWrite; r_addr1 = oChAddr; r_wd1 = oChWData;
      end else if (oChSel !== r_sel1 || oChWrite !== r_wr1 || oChAddr !== r_addr1 || oChWData !== r_wd1)
        r_unstable = 1;
      ack = noise ? (NUM_CH'($urandom) & ~(NUM_CH'(1) << ack_ch)) : '0;
      if (cyc - 1 == delay) ack |= NUM_CH'(1) << ack_ch;
      iChAck = ack;
      @(posedge clk); #1;
    end
    iReqValid = 1'b0; iChAck = '0;
    @(posedge clk); #1;
    r_ready_after = oReqReady; r_valid_after = oRspValid; r_rdata_after = oRspRData;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (oReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", oReqReady); end
    checks++; if (oRspValid !== 1'b0) begin errors++; $display("FAIL reset_rspvalid: got %b expected 0", oRspValid); end
    checks++; if (oChSel !== 4'b0) begin errors++; $display("FAIL reset_chsel: got %b expected 0000", oChSel); end
    checks++; if ({oRspRData, oRspError} !== 33'h0) begin errors++; $display("FAIL reset_rsp: got %h/%b expected 0/0", oRspRData, oRspError); end
    checks++; if ({oTimeoutCount, oLastErrAddr} !== 40'h0) begin errors++; $display("FAIL reset_counters: got %0d/%h expected 0/0", oTimeoutCount, oLastErrAddr); end
    rst = 1'b0; m_tmo = 0; m_last_err = '0;
    @(posedge clk); #1;
    checks++; if (oReqReady !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b expected 1", oReqReady); end
  endtask

  task automatic test_directed();
    chdata[2] = 32'h0000A5A5;
    do_txn(1'b0, 32'hFFFFFC24, 32'h0, 2, 2, 1'b0, 1'b0);
    $display("txn read ch2 off4: lat=%0d rdata=%h err=%b sel=%b", r_lat, r_rdata, r_err, r_sel1);
    checks++; if (r_sel1 !== 4'b0100 || r_addr1 !== 4'd4) begin errors++; $display("FAIL rd_ch2_sel: got %b/%0d expected 0100/4", r_sel1, r_addr1); end
    checks++; if (r_lat != 4) begin errors++; $display("FAIL rd_ch2_lat: got %0d expected 4", r_lat); end
    checks++; if (r_rdata !== 32'h0000A5A5 || r_err !== 1'b0) begin errors++; $display("FAIL rd_ch2_data: got %h/%b expected 0000a5a5/0", r_rdata, r_err); end
    checks++; if (r_ready_after !== 1'b1 || r_valid_after !== 1'b0) begin errors++; $display("FAIL rd_ch2_after: got ready=%b valid=%b expected 1/0", r_ready_after, r_valid_after); end

    do_txn(1'b1, 32'hFFFFFC00, 32'h12345678, 0, 0, 1'b0, 1'b0);
    $display("txn write ch0: lat=%0d rdata=%h err=%b wr=%b wd=%h", r_lat, r_rdata, r_err, r_wr1, r_wd1);
    checks++; if (r_wr1 !== 1'b1 || r_wd1 !== 32'h12345678 || r_sel1 !== 4'b0001) begin errors++; $display("FAIL wr_ch0_strobe: got %b/%h/%b expected 1/12345678/0001", r_wr1, r_wd1, r_sel1); end
    checks++; if (r_lat != 2 || r_err !== 1'b0 || r_rdata !== 32'h0) begin errors++; $display("FAIL wr_ch0_rsp: got lat=%0d err=%b rdata=%h expected 2/0/0", r_lat, r_err, r_rdata); end

    do_txn(1'b0, 32'h00001000, 32'h0, 0, 0, 1'b0, 1'b0);
    $display("txn read miss 00001000: lat=%0d rdata=%h err=%b", r_lat, r_rdata, r_err);
    checks++; if (r_sel_any !== 4'b0) begin errors++; $display("FAIL miss_sel: got %b expected 0000", r_sel_any); end
    checks++; if (r_lat != 1 || r_rdata !== ERR || r_err !== 1'b1) begin errors++; $display("FAIL miss_rsp: got lat=%0d %h/%b expected 1/deadbeef/1", r_lat, r_rdata, r_err); end
    checks++; if (oLastErrAddr !== 32'h00001000 || oTimeoutCount !== 8'd0) begin errors++; $display("FAIL miss_regs: got %h/%0d expected 00001000/0", oLastErrAddr, oTimeoutCount); end
    m_last_err = 32'h00001000;
  endtask

  task automatic test_random();
    logic        wr;
    logic [31:0] addr, wdata;
    int          delay, r;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NUM_CH; k++) chdata[k] = $urandom;
      wr = 1'($urandom_range(0, 1)); wdata = $urandom;
      r = $urandom_range(0, 5);
      case (r)
        0, 1, 2: addr = BASE + $urandom_range(0, 63);
        3:       addr = BASE - 32'd1 - $urandom_range(0, 15);
        4:       addr = BASE + 32'd64 + $urandom_range(0, 255);
        default: addr = $urandom;
      endcase
      r = $urandom_range(0, 9);
      delay = (r < 7) ? $urandom_range(0, TIMEOUT) : ((r == 7) ? -1 : TIMEOUT);
      model_txn(wr, addr, delay);
      do_txn(wr, addr, wdata, e_ch, delay, 1'b1, 1'($urandom_range(0, 1)));
      $display("txn rand %0d: wr=%b addr=%h delay=%0d lat=%0d rdata=%h err=%b", it, wr, addr, delay, r_lat, r_rdata, r_err);
      checks++; if (r_lat != e_lat) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", it, r_lat, e_lat); end
      checks++; if (r_rdata !== e_rdata || r_err !== e_err) begin errors++; $display("FAIL rand_rsp[%0d]: got %h/%b expected %h/%b", it, r_rdata, r_err, e_rdata, e_err); end
      if (e_hit) begin
        checks++; if (r_sel1 !== 4'(1 << e_ch) || r_addr1 !== 4'(e_off) || r_wr1 !== wr) begin errors++; $display("FAIL rand_chan[%0d]: got sel=%b addr=%0d wr=%b expected %b/%0d/%b", it, r_sel1, r_addr1, r_wr1, 4'(1 << e_ch), e_off, wr); end
        checks++; if (r_unstable) begin errors++; $display("FAIL rand_stable[%0d]: got unstable=1 expected 0", it); end
        if (wr) begin
          checks++; if (r_wd1 !== wdata) begin errors++; $display("FAIL rand_wdata[%0d]: got %h expected %h", it, r_wd1, wdata); end
        end
      end else begin
        checks++; if (r_sel_any !== 4'b0) begin errors++; $display("FAIL rand_miss_sel[%0d]: got %b expected 0000", it, r_sel_any); end
      end
      checks++; if (r_ready_after !== 1'b1 || r_valid_after !== 1'b0 || r_rdata_after !== e_rdata) begin errors++; $display("FAIL rand_after[%0d]: got ready=%b valid=%b rdata=%h expected 1/0/%h", it, r_ready_after, r_valid_after, r_rdata_after, e_rdata); end
      checks++; if (oTimeoutCount !== 8'(m_tmo) || oLastErrAddr !== m_last_err) begin errors++; $display("FAIL rand_regs[%0d]: got %0d/%h expected %0d/%h", it, oTimeoutCount, oLastErrAddr, m_tmo, m_last_err); end
    end
  endtask

  task automatic test_timeout_sat();
    test_reset();
    for (int it = 0; it < 256; it++) begin
      model_txn(1'b0, BASE + 32'h30, -1);
      do_txn(1'b0, BASE + 32'h30, 32'h0, 3, -1, 1'b0, 1'b0);
      if (it < 2 || it > 253) $display("txn timeout %0d: lat=%0d rdata=%h err=%b count=%0d", it, r_lat, r_rdata, r_err, oTimeoutCount);
      checks++; if (r_lat != TIMEOUT + 2 || r_rdata !== ERR || r_err !== 1'b1) begin errors++; $display("FAIL tmo_rsp[%0d]: got lat=%0d %h/%b expected %0d/deadbeef/1", it, r_lat, r_rdata, r_err, TIMEOUT + 2); end
      checks++; if (oTimeoutCount !== 8'(m_tmo)) begin errors++; $display("FAIL tmo_count[%0d]: got %0d expected %0d", it, oTimeoutCount, m_tmo); end
    end
    checks++; if (oTimeoutCount !== 8'd255 || oLastErrAddr !== BASE + 32'h30) begin errors++; $display("FAIL tmo_saturate: got %0d/%h expected 255/%h", oTimeoutCount, oLastErrAddr, BASE + 32'h30); end
  endtask

  task automatic test_ack_at_timeout();
    chdata[1] = $urandom;
    model_txn(1'b0, BASE + 32'h18, TIMEOUT);
    do_txn(1'b0, BASE + 32'h18, 32'h0, 1, TIMEOUT, 1'b1, 1'b0);
    $display("txn ack at timeout ch1: lat=%0d rdata=%h err=%b", r_lat, r_rdata, r_err);
    checks++; if (r_lat != TIMEOUT + 2) begin errors++; $display("FAIL ack_tmo_lat: got %0d expected %0d", r_lat, TIMEOUT + 2); end
    checks++; if (r_rdata !== chdata[1] || r_err !== 1'b0) begin errors++; $display("FAIL ack_tmo_rsp: got %h/%b expected %h/0", r_rdata, r_err, chdata[1]); end
    checks++; if (oTimeoutCount !== 8'(m_tmo)) begin errors++; $display("FAIL ack_tmo_count: got %0d expected %0d", oTimeoutCount, m_tmo); end
  endtask

  task automatic test_mid_reset();
    bit seen = 0;
    iReqValid = 1'b1; iReqWrite = 1'b0; iReqAddr = BASE + 32'h20;
    @(posedge clk); #1;
    iReqValid = 1'b0;
    checks++; if (oChSel !== 4'b0100) begin errors++; $display("FAIL midrst_wait_sel: got %b expected 0100", oChSel); end
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    $display("txn reset mid-WAIT: sel=%b ready=%b", oChSel, oReqReady);
    checks++; if (oChSel !== 4'b0 || oReqReady !== 1'b1) begin errors++; $display("FAIL midrst_immediate: got sel=%b ready=%b expected 0000/1", oChSel, oReqReady); end
    repeat (2) begin @(posedge clk); #1; if (oRspValid !== 1'b0) seen = 1; end
    rst = 1'b0; m_tmo = 0; m_last_err = '0;
    repeat (3) begin @(posedge clk); #1; if (oRspValid !== 1'b0) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_rsp: got oRspValid=1 expected 0"); end
    chdata[2] = $urandom;
    do_txn(1'b0, BASE + 32'h2C, 32'h0, 2, 1, 1'b0, 1'b0);
    $display("txn after reset read ch2: lat=%0d rdata=%h err=%b", r_lat, r_rdata, r_err);
    checks++; if (r_lat != 3 || r_rdata !== chdata[2] || r_err !== 1'b0) begin errors++; $display("FAIL midrst_recover: got lat=%0d %h/%b expected 3/%h/0", r_lat, r_rdata, r_err, chdata[2]); end
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) chdata[k] = '0;
    test_reset();
    test_directed();
    test_random();
    test_ack_at_timeout();
    test_timeout_sat();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
